uart_rx: RTL and testbench

Serial-to-parallel UART receiver; the consumer of the serial line that `uart_tx` drives. It takes 8N1 frames, LSB first, at a runtime-programmable bit period. It samples each bit at its mid-point and returns one received byte per frame, with a one-cycle valid strobe. It sits at the input of the image-processing path: host pixel bytes enter here before buffering and processing, and it serves as the loopback checker for `uart_tx`.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and the
// smallest bit period the receiver will accept.
package uart_pkg;

    localparam int UART_DATA_WIDTH   = 8;
    localparam int UART_MIN_BAUD_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer plus a history flop for edge detection.
// Resets to 1 so an idle-high line shows no edge out of reset.
module uart_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic hist
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime bit period, mid-bit sampling and
// one-cycle valid / frame-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk_i_rx,
    input  logic                  rsnt_i_rx,
    input  logic                  data_i_serial_rx,
    input  logic [DATA_WIDTH*2:0] baud_div_i_rx,
    output logic [DATA_WIDTH-1:0] data_o_rx,
    output logic                  valid_o_rx,
    output logic                  frame_err_o_rx,
    output logic                  active_o_rx
);

    localparam int CW = DATA_WIDTH * 2 + 1;
    localparam int IW = $clog2(DATA_WIDTH);

    logic line_sync;
    logic line_hist;
    logic fall_q;

    uart_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    uart_sync_2ff u_sync (
        .clk   (clk_i_rx),
        .rst_n (rsnt_i_rx),
        .din   (data_i_serial_rx),
        .sync  (line_sync),
        .hist  (line_hist)
    );

    always_ff @(posedge clk_i_rx or negedge rsnt_i_rx) begin
        if (!rsnt_i_rx) begin
            fall_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            fall_q  <= line_hist & ~line_sync;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        div_d   = div_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall_q && baud_div_i_rx >= CW'(UART_MIN_BAUD_DIV)) begin
                    div_d   = baud_div_i_rx;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == (div_q >> 1) - CW'(1)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A high start sample is a glitch, not a frame
                    state_d = line_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == div_q - CW'(1)) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = line_sync;
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == div_q - CW'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (line_sync) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_o_rx      = data_q;
    assign valid_o_rx     = valid_q;
    assign frame_err_o_rx = ferr_q;
    assign active_o_rx    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed-random bench for uart_rx: a bench-side serial driver plus a
// frame-level reference model of expected strobes, bytes and timing.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic        ser;
    logic [16:0] baud;
    logic [7:0]  data;
    logic        valid;
    logic        ferr;
    logic        active;

    int cyc;
    int n_total;
    int n_pass;
    int n_fail;
    int n_both;
    int act_rise;
    int act_fall;
    logic act_prev;

    int ev_kind[$];
    int ev_data[$];
    int ev_cyc[$];
    int exp_kind[$];
    int exp_data[$];
    int exp_cyc[$];
    logic [7:0] last_good;
    logic [7:0] rb;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk_i_rx         (clk),
        .rsnt_i_rx        (rst_n),
        .data_i_serial_rx (ser),
        .baud_div_i_rx    (baud),
        .data_o_rx        (data),
        .valid_o_rx       (valid),
        .frame_err_o_rx   (ferr),
        .active_o_rx      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            ev_kind.push_back(1);
            ev_data.push_back(int'(data));
            ev_cyc.push_back(cyc);
        end
        if (ferr) begin
            ev_kind.push_back(2);
            ev_data.push_back(int'(data));
            ev_cyc.push_back(cyc);
        end
        if (valid && ferr) n_both++;
        if (active && !act_prev) act_rise = cyc;
        if (!active && act_prev) act_fall = cyc;
        act_prev = active;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives one frame. abort_bit >= 0 pulses reset mid-way through that
    // data bit; chg_bit >= 0 reprograms baud at the start of that bit.
    task automatic send_frame(input logic [7:0] b, input int div,
                              input bit stop_ok, input int abort_bit,
                              input int chg_bit, input int chg_div,
                              input bit expect_rx, output int e0);
        @(posedge clk);
        #1;
        e0  = cyc + 1;
        ser = 1'b0;
        if (expect_rx && abort_bit < 0) begin
            exp_kind.push_back(stop_ok ? 1 : 2);
            exp_cyc.push_back(e0 + 3 + (div >> 1) + 9 * div);
            if (stop_ok) last_good = b;
            exp_data.push_back(int'(last_good));
        end
        repeat (div) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 ser = b[k];
            if (k == chg_bit) baud = 17'(chg_div);
            if (k == abort_bit) begin
                repeat (div / 2) @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                chk("rst_data", 32'(data), 32'h0);
                chk("rst_valid", 32'(valid), 32'h0);
                chk("rst_ferr", 32'(ferr), 32'h0);
                chk("rst_active", 32'(active), 32'h0);
                ser = 1'b1;
                last_good = 8'h00;
                repeat (5) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            repeat (div) @(posedge clk);
        end
        #1 ser = stop_ok;
        repeat (div) @(posedge clk);
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, "_count"}, 32'(ev_kind.size()), 32'(exp_kind.size()));
        n = ev_kind.size() < exp_kind.size() ? ev_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, 32'(ev_kind[i]), 32'(exp_kind[i]));
            chk({tag, "_data"}, 32'(ev_data[i]), 32'(exp_data[i]));
            chk({tag, "_edge"}, 32'(ev_cyc[i]), 32'(exp_cyc[i]));
        end
        ev_kind.delete();
        ev_data.delete();
        ev_cyc.delete();
        exp_kind.delete();
        exp_data.delete();
        exp_cyc.delete();
    endtask

    initial begin
        int e0;
        n_total   = 0;
        n_pass    = 0;
        n_fail    = 0;
        n_both    = 0;
        act_rise  = -1;
        act_fall  = -1;
        act_prev  = 1'b0;
        cyc       = 0;
        last_good = 8'h00;
        ser       = 1'b1;
        baud      = 17'd868;
        rst_n     = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_ferr", 32'(ferr), 32'h0);
        chk("reset_active", 32'(active), 32'h0);
        repeat (5) @(posedge clk);

        send_frame(8'hA5, 868, 1'b1, -1, -1, 0, 1'b1, e0);
        repeat (10) @(posedge clk);
        chk("a5_act_rise", 32'(act_rise), 32'(e0 + 3));
        chk("a5_act_fall", 32'(act_fall), 32'(e0 + 3 + 434 + 7812));
        check_events("a5");

        baud = 17'd64;
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 64, 1'b1, -1, -1, 0, 1'b1, e0);
        end
        repeat (10) @(posedge clk);
        check_events("rand");

        baud = 17'd200;
        send_frame(8'h3C, 200, 1'b0, -1, -1, 0, 1'b1, e0);
        repeat (10) @(posedge clk);
        chk("ferr_data_held", 32'(data), 32'(last_good));
        check_events("ferr");
        repeat (400) @(posedge clk);
        #1 chk("break_events", 32'(ev_kind.size()), 32'h0);
        ser = 1'b1;
        repeat (20) @(posedge clk);

        baud = 17'd868;
        @(posedge clk);
        #1;
        e0  = cyc + 1;
        ser = 1'b0;
        repeat (200) @(posedge clk);
        #1 ser = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("glitch_active", 32'(active), 32'h0);
        chk("glitch_rise", 32'(act_rise), 32'(e0 + 3));
        chk("glitch_fall", 32'(act_fall), 32'(e0 + 3 + 434));
        check_events("glitch");

        baud = 17'd200;
        send_frame(8'h5A, 200, 1'b1, 4, -1, 0, 1'b1, e0);
        repeat (20) @(posedge clk);
        check_events("abort");
        send_frame(8'h81, 200, 1'b1, -1, -1, 0, 1'b1, e0);
        repeat (10) @(posedge clk);
        chk("post_rst_data", 32'(data), 32'h81);
        check_events("post_rst");

        baud = 17'd868;
        rb   = 8'($urandom);
        send_frame(rb, 868, 1'b1, -1, 2, 434, 1'b1, e0);
        repeat (10) @(posedge clk);
        check_events("chg_old");
        rb = 8'($urandom);
        send_frame(rb, 434, 1'b1, -1, -1, 0, 1'b1, e0);
        repeat (10) @(posedge clk);
        check_events("chg_new");

        baud = 17'd3;
        send_frame(8'h00, 3, 1'b1, -1, -1, 0, 1'b0, e0);
        send_frame(8'h55, 3, 1'b1, -1, -1, 0, 1'b0, e0);
        repeat (20) @(posedge clk);
        #1 chk("div3_active", 32'(act_prev), 32'h0);
        check_events("div3");
        chk("no_overlap", 32'(n_both), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
